instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage directly upstream of instr_mem: owns the PC, drives the instruction BRAM port (addr/en/we/din) and consumes its 1-cycle-latency read data.
- Presents {instr, pc} to decode through a valid/ready handshake.
- Absorbs downstream backpressure with a 1-entry skid register.
- Redirect (branch/jump/trap) restarts fetch at a new PC with zero bubble and kills stale words.

Parameters:
- XLEN, 32, width of PC and instruction.
- RESET_PC, 32'h0000_0000, PC fetched first after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  restart fetch at redirect_pc this cycle.
- redirect_pc  in  XLEN  new byte PC; bits[1:0] ignored (forced 0).
- imem_en  out  1  BRAM enable; a read is issued in each cycle it is 1.
- imem_we  out  1  constant 0 (fetch never writes).
- imem_addr  out  XLEN  byte address of the issued read.
- imem_din  out  XLEN  constant 0.
- imem_dout  in  XLEN  read data, valid the cycle after issue.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts this cycle.
- out_instr  out  XLEN  instruction word.
- out_pc  out  XLEN  PC of out_instr.

Behaviour:
- State: pc_q (next PC to issue); resp_valid/resp_pc (read issued last cycle, not killed); skid_valid/skid_instr/skid_pc.
- Reset, synchronous while rst=1: pc_q=RESET_PC, resp_valid=0, skid_valid=0, and skid_instr/skid_pc=0. Outputs during rst: imem_en=0, out_valid=0. First issue is in the first cycle after rst drops, at addr RESET_PC.
- Output mux:
  - out_valid = (skid_valid | resp_valid) & ~redirect_valid.
  - out_instr/out_pc come from skid if skid_valid, else {imem_dout, resp_pc}.
- Invariant: skid_valid and resp_valid are never both 1. The issue rule guarantees this.
- Skid next-state: skid_nxt = ~redirect_valid & (skid_valid | resp_valid) & ~out_ready.
  - When resp_valid and skid_nxt: skid captures {imem_dout, resp_pc}.
  - When skid_valid and skid_nxt: skid holds.
- Issue rule: imem_en = ~rst & (redirect_valid | ~skid_nxt).
  - Note: combinational path from out_ready to imem_en.
- Address: imem_addr = redirect_valid ? {redirect_pc[XLEN-1:2],2'b00} : pc_q.
- When imem_en=1:
  - resp_valid<=1 and resp_pc<=imem_addr.
  - pc_q<=imem_addr+4, wrapping modulo 2^XLEN.
- When imem_en=0: resp_valid<=0 and pc_q holds. The BRAM is not re-read.
- Redirect (has priority over everything except rst):
  - Kills the in-flight resp and the skid content; out_valid=0 that cycle.
  - Issues redirect_pc the same cycle, so the target instruction is presented on the next cycle.
- Redirect held over consecutive cycles: each cycle restarts at its redirect_pc; only the last one survives.
- Throughput: 1 instr/cycle when out_ready=1 continuously. Fetch latency is 1 cycle from issue to out_valid.
- Backpressure: out_ready=0 with data pending moves the data into skid and stops issue. Data is never dropped or duplicated.
- Handshake: once out_valid=1, out_instr/out_pc are stable until accepted or killed by redirect/rst.
- rst mid-stream drops all pending words; nothing is presented until after restart at RESET_PC.

Decomposition:
- Shared package cpu_pkg holds: XLEN, RESET_PC default, INSTR_BYTES=4, and a fetch_pkt typedef {instr, pc}. Decode uses the same typedef.
- One natural sub-module, fetch_skid_buffer: 1-entry pipeline register with valid/ready, flush, and a skid_nxt output. instr_fetch keeps the PC and issue logic.

Test Plan:
- Reset then out_ready=1 for 5 cycles: imem_addr goes 0,4,8,C,10. out_valid rises the cycle after rst drops+1. out_pc goes 0,4,8,C with matching imem_dout.
- Stall: out_ready=0 for 3 cycles while PC=8 is presented. out_pc stays 8, instr is stable, and imem_en=0 after the first stall cycle. On release, out_pc goes 8,C,10 with no gap or duplicate.
- Redirect to 0x40 while a word for PC=0xC is in flight: that cycle out_valid=0 and imem_addr=0x40. Next cycle out_pc=0x40, then 0x44.
- Redirect during stall with skid full (pc=0x10): skid flushed. Next output is redirect_pc=0x83 aligned to 0x80, never 0x10.
- Assert rst for 1 cycle mid-stream at PC=0x20: out_valid=0 during rst. Fetch restarts at RESET_PC=0 and no pre-reset word appears.
- PC wrap: redirect to 0xFFFF_FFFC, then out_pc goes 0xFFFF_FFFC, 0x0000_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Holds XLEN, reset PC, instruction size and the fetch->decode packet.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  localparam logic [XLEN-1:0] ALIGN_MASK = INSTR_BYTES - 32'd1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] pc
  );
    return pc & ~ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch bus: redirect in, instruction BRAM port, decode handshake out.
// master = fetch stage, slave = environment (BRAM + decode + redirect).
interface instr_fetch_if #(
  parameter int XLEN = 32
);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            imem_en;
  logic            imem_we;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_din;
  logic [XLEN-1:0] imem_dout;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    output imem_en,
    output imem_we,
    output imem_addr,
    output imem_din,
    input  imem_dout,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    input  imem_en,
    input  imem_we,
    input  imem_addr,
    input  imem_din,
    output imem_dout,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// 1-entry skid register between BRAM response and decode.
// Ports: in_* (BRAM response), flush, out_* (to decode), skid_nxt.
module fetch_skid_buffer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  input  fetch_pkt_t in_pkt,
  input  logic       out_ready,
  output logic       out_valid,
  output fetch_pkt_t out_pkt,
  output logic       skid_nxt
);

  logic       skid_valid;
  fetch_pkt_t skid_pkt;
  logic       pend;

  // in_valid and skid_valid are never both set: issue stops
  // whenever the skid is about to fill.
  assign pend      = skid_valid | in_valid;
  assign skid_nxt  = ~flush & pend & ~out_ready;
  assign out_valid = pend & ~flush;
  assign out_pkt   = skid_valid ? skid_pkt : in_pkt;

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_pkt   <= '0;
    end else begin
      skid_valid <= skid_nxt;
      if (in_valid & skid_nxt) begin
        skid_pkt <= in_pkt;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the instruction BRAM and hands
// {instr, pc} to decode. Ports: clk, rst, bus (instr_fetch_if.master).
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RST_PC = RESET_PC
)(
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  logic [XLEN-1:0] pc_q;
  logic            resp_valid;
  logic [XLEN-1:0] resp_pc;
  logic            skid_nxt;
  logic            flush;
  logic            en;
  logic [XLEN-1:0] addr;
  fetch_pkt_t      resp_pkt;
  fetch_pkt_t      out_pkt;

  // rst also flushes so nothing is presented while it is held.
  assign flush = bus.redirect_valid | rst;

  // Comb path out_ready -> imem_en: stop issuing when the
  // pending word has to park in the skid.
  assign en   = ~rst & (bus.redirect_valid | ~skid_nxt);
  assign addr = bus.redirect_valid ? align_pc(bus.redirect_pc)
                                   : pc_q;

  assign bus.imem_en   = en;
  assign bus.imem_we   = 1'b0;
  assign bus.imem_addr = addr;
  assign bus.imem_din  = '0;

  assign resp_pkt.instr = bus.imem_dout;
  assign resp_pkt.pc    = resp_pc;

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (resp_valid),
    .in_pkt    (resp_pkt),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_pkt   (out_pkt),
    .skid_nxt  (skid_nxt)
  );

  assign bus.out_instr = out_pkt.instr;
  assign bus.out_pc    = out_pkt.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RST_PC;
      resp_valid <= 1'b0;
      resp_pc    <= '0;
    end else begin
      resp_valid <= en;
      if (en) begin
        resp_pc <= addr;
        pc_q    <= addr + INSTR_BYTES;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 1-cycle BRAM model.
// Inputs change at negedge, outputs are checked 1ns later.
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_if #(.XLEN(32)) bus ();

  instr_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_dout <= mem(bus.imem_addr);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc(input logic r, input logic rdy,
                     input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    rst = r;
    bus.out_ready = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    #1;
  endtask

  task automatic out_is(input string tag, input logic [31:0] pc);
    chk({tag, "_v"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_pc"}, bus.out_pc, pc);
    chk({tag, "_in"}, bus.out_instr, mem(pc));
  endtask

  task automatic iss(input string tag, input logic [31:0] a);
    chk({tag, "_en"}, 32'(bus.imem_en), 32'd1);
    chk({tag, "_ad"}, bus.imem_addr, a);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_dout = '0;

    cyc(1, 1, 0, 0);
    chk("rst_en", 32'(bus.imem_en), 0);
    chk("rst_ov", 32'(bus.out_valid), 0);
    cyc(1, 1, 0, 0);
    chk("rst_en2", 32'(bus.imem_en), 0);
    chk("we", 32'(bus.imem_we), 0);
    chk("din", bus.imem_din, 0);

    cyc(0, 1, 0, 0);
    iss("c1", 32'h0);
    chk("c1_ov", 32'(bus.out_valid), 0);
    cyc(0, 1, 0, 0);
    iss("c2", 32'h4);
    out_is("c2", 32'h0);
    cyc(0, 1, 0, 0);
    iss("c3", 32'h8);
    out_is("c3", 32'h4);

    // stall with PC 8 presented
    cyc(0, 0, 0, 0);
    out_is("s1", 32'h8);
    chk("s1_en", 32'(bus.imem_en), 0);
    cyc(0, 0, 0, 0);
    out_is("s2", 32'h8);
    chk("s2_en", 32'(bus.imem_en), 0);
    cyc(0, 0, 0, 0);
    out_is("s3", 32'h8);
    chk("s3_en", 32'(bus.imem_en), 0);
    cyc(0, 1, 0, 0);
    out_is("r1", 32'h8);
    iss("r1", 32'hC);
    cyc(0, 1, 0, 0);
    out_is("r2", 32'hC);
    iss("r2", 32'h10);

    // redirect while 0x10 is in flight
    cyc(0, 1, 1, 32'h40);
    chk("rd_ov", 32'(bus.out_valid), 0);
    iss("rd", 32'h40);
    cyc(0, 1, 0, 0);
    out_is("rd1", 32'h40);
    iss("rd1", 32'h44);
    cyc(0, 1, 0, 0);
    out_is("rd2", 32'h44);

    // fill skid with 0x48, then redirect to 0x83
    cyc(0, 0, 0, 0);
    out_is("sk", 32'h48);
    chk("sk_en", 32'(bus.imem_en), 0);
    cyc(0, 0, 1, 32'h83);
    chk("skr_ov", 32'(bus.out_valid), 0);
    iss("skr", 32'h80);
    cyc(0, 0, 0, 0);
    out_is("skr1", 32'h80);
    chk("skr1_en", 32'(bus.imem_en), 0);
    cyc(0, 1, 0, 0);
    out_is("skr2", 32'h80);
    iss("skr2", 32'h84);
    cyc(0, 1, 0, 0);
    out_is("skr3", 32'h84);

    // reset mid-stream
    cyc(1, 1, 0, 0);
    chk("mr_ov", 32'(bus.out_valid), 0);
    chk("mr_en", 32'(bus.imem_en), 0);
    cyc(0, 1, 0, 0);
    chk("mr1_ov", 32'(bus.out_valid), 0);
    iss("mr1", 32'h0);
    cyc(0, 1, 0, 0);
    out_is("mr2", 32'h0);

    // PC wrap
    cyc(0, 1, 1, 32'hFFFF_FFFC);
    chk("w_ov", 32'(bus.out_valid), 0);
    iss("w", 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0);
    out_is("w1", 32'hFFFF_FFFC);
    iss("w1", 32'h0);
    cyc(0, 1, 0, 0);
    out_is("w2", 32'h0);
    iss("w2", 32'h4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
